// File: rtl/uib_pkg.sv
// Shared definitions for uib slave endpoints: access modes, slave FSM states
// and mode decoding helpers.
package uib_pkg;

    // Number of upper address bits consumed by the interconnect for slave select
    localparam int unsigned SLAVE_WIDTH = 4;

    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } uib_slv_state_t;

    // True for the five encodings that describe a real access
    function automatic logic mode_legal(input logic [2:0] mode);
        logic legal;
        case (mode)
            MODE_B, MODE_H, MODE_W, MODE_BU, MODE_HU: legal = 1'b1;
            default:                                  legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/uib_lane_align.sv
// Byte-lane steering between right-aligned uib data and a 32-bit memory word.
// Write side produces byte enables and a lane-replicated write word; read side
// selects and extends the addressed lane. Illegal modes yield no enables and 0.
module uib_lane_align
    import uib_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      i_mode,
    input  logic [1:0]      i_lane,
    input  logic [XLEN-1:0] i_wdat,
    input  logic [XLEN-1:0] i_rword,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wword,
    output logic [XLEN-1:0] o_rdat
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Decode mode and lane into enables, write word and extended read data
    always_comb begin
        w_byte  = i_rword[{i_lane, 3'b000} +: 8];
        w_half  = i_lane[1] ? i_rword[31:16] : i_rword[15:0];
        o_be    = 4'b0000;
        o_wword = '0;
        o_rdat  = '0;
        case (i_mode)
            MODE_B, MODE_BU: begin
                o_be    = 4'b0001 << i_lane;
                // Replicate so every lane carries the byte; the enable picks one
                o_wword = {4{i_wdat[7:0]}};
                o_rdat  = (i_mode == MODE_B) ? {{24{w_byte[7]}}, w_byte}
                                             : {24'b0, w_byte};
            end
            MODE_H, MODE_HU: begin
                o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wword = {2{i_wdat[15:0]}};
                o_rdat  = (i_mode == MODE_H) ? {{16{w_half[15]}}, w_half}
                                             : {16'b0, w_half};
            end
            MODE_W: begin
                o_be    = 4'b1111;
                o_wword = i_wdat;
                o_rdat  = i_rword;
            end
            default: begin
                o_be    = 4'b0000;
                o_wword = '0;
                o_rdat  = '0;
            end
        endcase
    end

endmodule

// File: rtl/uib_sram_slave.sv
// uib slave endpoint backed by a word-organised SRAM. Requests wait LATENCY
// cycles, then complete with a one-cycle ready pulse carrying registered
// read data. Writes commit on the edge that ends the response cycle.
module uib_sram_slave
    import uib_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 32 - SLAVE_WIDTH,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic              i_wen,
    input  logic [2:0]        i_mode,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [XLEN-1:0]   i_dat,
    output logic [XLEN-1:0]   o_dat,
    output logic              o_ready
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam bit          ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0]  CNT_INIT = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

    uib_slv_state_t    r_state;
    logic [3:0]        r_cnt;
    logic              r_ready;
    logic [XLEN-1:0]   r_dat;
    logic [XLEN-1:0]   r_mem [DEPTH];

    logic [IDX_W-1:0]  w_idx;
    logic [XLEN-1:0]   w_rword;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wword;
    logic [XLEN-1:0]   w_rdat;
    logic              w_load;
    logic              w_we;
    logic              w_unused_addr;

    // Upper address bits fall outside the array, so accesses wrap
    assign w_idx         = i_addr[IDX_W+1:2];
    assign w_unused_addr = ^i_addr[ADDR_W-1:IDX_W+2];
    assign w_rword       = r_mem[w_idx];

    uib_lane_align #(
        .XLEN (XLEN)
    ) u_lane_align (
        .i_mode  (i_mode),
        .i_lane  (i_addr[1:0]),
        .i_wdat  (i_dat),
        .i_rword (w_rword),
        .o_be    (w_be),
        .o_wword (w_wword),
        .o_rdat  (w_rdat)
    );

    // Flag the edge that moves the FSM into RESP
    always_comb begin
        w_load = 1'b0;
        case (r_state)
            IDLE:    w_load = i_req && ZERO_LAT;
            WAIT:    w_load = i_req && (r_cnt == 4'd0);
            default: w_load = 1'b0;
        endcase
    end

    assign w_we = (r_state == RESP) && i_req && i_wen && mode_legal(i_mode);

    // Handshake FSM with wait counter, registered ready and read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_ready <= w_load;
            r_dat   <= (w_load && !i_wen && mode_legal(i_mode)) ? w_rdat : '0;
            case (r_state)
                IDLE: begin
                    if (i_req) begin
                        if (ZERO_LAT) begin
                            r_state <= RESP;
                        end else begin
                            r_cnt   <= CNT_INIT;
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!i_req) begin
                        r_state <= IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Byte-masked SRAM write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wword[b*8 +: 8];
                end
            end
        end
    end

    // A master that drops req during RESP sees no read data
    assign o_dat   = i_req ? r_dat : '0;
    assign o_ready = r_ready;

endmodule

// File: tb/tb_uib_sram_slave.sv
// Directed bench for uib_sram_slave: three instances at LATENCY 0, 1 and 3
// share the request bus; each has its own req line and outputs.
module tb_uib_sram_slave;
    import uib_pkg::*;

    localparam int unsigned AW = 32 - SLAVE_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    req;
    logic          wen;
    logic [2:0]    mode;
    logic [AW-1:0] addr;
    logic [31:0]   wdat;
    logic [2:0]    ready;
    logic [31:0]   rdat [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uib_sram_slave #(.XLEN(32), .ADDR_W(AW), .DEPTH(1024), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .i_req(req[0]), .i_wen(wen), .i_mode(mode),
        .i_addr(addr), .i_dat(wdat), .o_dat(rdat[0]), .o_ready(ready[0])
    );
    uib_sram_slave #(.XLEN(32), .ADDR_W(AW), .DEPTH(1024), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .i_req(req[1]), .i_wen(wen), .i_mode(mode),
        .i_addr(addr), .i_dat(wdat), .o_dat(rdat[1]), .o_ready(ready[1])
    );
    uib_sram_slave #(.XLEN(32), .ADDR_W(AW), .DEPTH(1024), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .i_req(req[2]), .i_wen(wen), .i_mode(mode),
        .i_addr(addr), .i_dat(wdat), .o_dat(rdat[2]), .o_ready(ready[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called and returns at posedge+1. lat = clock edges from acceptance to ready.
    task automatic txn(input int sel, input logic w, input logic [2:0] m,
                       input logic [AW-1:0] a, input logic [31:0] d, input bit keep,
                       output logic [31:0] rd, output int lat);
        wen      = w;
        mode     = m;
        addr     = a;
        wdat     = d;
        req[sel] = 1'b1;
        lat      = -1;
        rd       = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ready[sel]) begin
                lat = n - 1;
                rd  = rdat[sel];
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) req[sel] = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input int sel, input logic [2:0] m,
                          input logic [AW-1:0] a, input logic [31:0] d, input int exp_lat);
        logic [31:0] rd;
        int lat;
        txn(sel, 1'b1, m, a, d, 1'b0, rd, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic rd_chk(input string tag, input int sel, input logic [2:0] m,
                          input logic [AW-1:0] a, input logic [31:0] exp, input int exp_lat);
        logic [31:0] rd;
        int lat;
        txn(sel, 1'b0, m, a, 32'h0, 1'b0, rd, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk(tag, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] b2b_exp [3];
        int lat;
        int pulses;

        rst_n = 1'b0;
        req   = 3'b000;
        wen   = 1'b0;
        mode  = MODE_W;
        addr  = '0;
        wdat  = '0;

        // Reset state
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", {31'b0, ready[i]}, 32'h0);
            chk("rst_dat", rdat[i], 32'h0);
        end
        chk("rst_state", 32'(u_lat3.r_state), 32'(IDLE));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Word write then read at LATENCY=1; dat_o must clear the cycle after ready
        wr_chk("w_wr", 1, MODE_W, 'h10, 32'hDEADBEEF, 2);
        txn(1, 1'b0, MODE_W, 'h10, 32'h0, 1'b1, rd, lat);
        chk("w_rd_lat", 32'(lat), 32'd2);
        chk("w_rd", rd, 32'hDEADBEEF);
        @(negedge clk);
        chk("w_rd_after_dat", rdat[1], 32'h0);
        chk("w_rd_after_ready", {31'b0, ready[1]}, 32'h0);
        @(posedge clk);
        #1 req[1] = 1'b0;
        @(posedge clk);
        #1;

        // Sign and zero extension
        wr_chk("ext_wr", 1, MODE_W, 'h20, 32'h80FF7F01, 2);
        rd_chk("lb3", 1, MODE_B, 'h23, 32'hFFFFFF80, 2);
        rd_chk("lbu3", 1, MODE_BU, 'h23, 32'h00000080, 2);
        rd_chk("lb1", 1, MODE_B, 'h21, 32'h0000007F, 2);
        rd_chk("lh2", 1, MODE_H, 'h22, 32'hFFFF80FF, 2);
        rd_chk("lhu0", 1, MODE_HU, 'h20, 32'h00007F01, 2);

        // Masked stores; upper write-data bits must not leak
        wr_chk("msk_wr", 1, MODE_W, 'h30, 32'h11223344, 2);
        wr_chk("sb1", 1, MODE_B, 'h31, 32'h123456AA, 2);
        rd_chk("sb1_rd", 1, MODE_W, 'h30, 32'h1122AA44, 2);
        wr_chk("sh2", 1, MODE_H, 'h32, 32'h5555BEEF, 2);
        rd_chk("sh2_rd", 1, MODE_W, 'h30, 32'hBEEFAA44, 2);

        // Back-to-back reads at LATENCY=0 with req held high
        b2b_exp[0] = 32'h11110000;
        b2b_exp[1] = 32'h22220001;
        b2b_exp[2] = 32'h33330002;
        for (int i = 0; i < 3; i++) wr_chk("b2b_wr", 0, MODE_W, AW'(i * 4), b2b_exp[i], 1);
        for (int i = 0; i < 3; i++) begin
            txn(0, 1'b0, MODE_W, AW'(i * 4), 32'h0, i < 2, rd, lat);
            chk("b2b_lat", 32'(lat), 32'd1);
            chk("b2b_dat", rd, b2b_exp[i]);
        end

        // Abort in WAIT at LATENCY=3: no ready, no write
        wr_chk("ab_wr", 2, MODE_W, 'h40, 32'hCAFEF00D, 4);
        wen  = 1'b1;
        mode = MODE_W;
        addr = 'h40;
        wdat = 32'h12345678;
        req[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1 req[2] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready[2]) pulses++;
        end
        chk("ab_ready", 32'(pulses), 32'd0);
        @(posedge clk);
        #1;
        rd_chk("ab_rd", 2, MODE_W, 'h40, 32'hCAFEF00D, 4);

        // Reset pulse during WAIT
        wen  = 1'b1;
        addr = 'h40;
        wdat = 32'h55555555;
        req[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rw_ready", {31'b0, ready[2]}, 32'h0);
        chk("rw_state", 32'(u_lat3.r_state), 32'(IDLE));
        req[2] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd_chk("rw_rd", 2, MODE_W, 'h40, 32'hCAFEF00D, 4);

        // Address wrap and illegal modes
        wr_chk("wrap_wr", 1, MODE_W, 'h1000, 32'hA5A51234, 2);
        rd_chk("wrap_rd", 1, MODE_W, 'h0, 32'hA5A51234, 2);
        wr_chk("ill_wr", 1, 3'b111, 'h10, 32'h0, 2);
        rd_chk("ill_chk", 1, MODE_W, 'h10, 32'hDEADBEEF, 2);
        rd_chk("ill_rd", 1, 3'b011, 'h10, 32'h0, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
